// File: rtl/conversor_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Three BCD digits cover every input value up to 511.
package conversor_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIM  = 2'd2
  } estado_t;

  localparam int N_DIGITS    = 3;
  localparam int BCD_W       = 4;
  localparam int BCD_TOTAL_W = N_DIGITS * BCD_W;

endpackage

// File: rtl/ajuste_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module ajuste_add3
  import conversor_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_nibble,
  output logic [BCD_W-1:0] o_nibble
);

  // Add-3 correction, wrapping modulo 16
  always_comb begin
    o_nibble = i_nibble;
    if (i_nibble >= 4'd5) begin
      o_nibble = i_nibble + 4'd3;
    end else begin
      o_nibble = i_nibble;
    end
  end

endmodule

// File: rtl/conversor_bcd_8bits.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Digits are published only on completion, so the display never sees partial values.
module conversor_bcd_8bits
  import conversor_bcd_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [3:0]        centenas,
  output logic [3:0]        dezenas,
  output logic [3:0]        unidades
);

  localparam int         SR_W      = BCD_TOTAL_W + N_BITS;
  localparam logic [3:0] LP_ULTIMO = 4'(N_BITS - 1);

  estado_t          r_estado;
  estado_t          w_estado_prox;
  logic [SR_W-1:0]  r_desloc;
  logic [SR_W-1:0]  w_ajustado;
  logic [SR_W-1:0]  w_deslocado;
  logic [3:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] r_cent;
  logic [BCD_W-1:0] r_dez;
  logic [BCD_W-1:0] r_uni;
  logic             w_ultimo;
  logic             w_busy_prox;
  logic             w_done_prox;

  // Per-digit add-3 correction ahead of the shift
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_ajuste
    ajuste_add3 u_ajuste (
      .i_nibble(r_desloc[N_BITS + g*BCD_W +: BCD_W]),
      .o_nibble(w_ajustado[N_BITS + g*BCD_W +: BCD_W])
    );
  end

  assign w_ajustado[N_BITS-1:0] = r_desloc[N_BITS-1:0];
  assign w_deslocado            = {w_ajustado[SR_W-2:0], 1'b0};
  assign w_ultimo               = (r_cnt == LP_ULTIMO);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Next-state logic; start is only honoured outside CONV
  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      IDLE: begin
        if (start) w_estado_prox = CONV;
        else       w_estado_prox = IDLE;
      end
      CONV: begin
        if (w_ultimo) w_estado_prox = FIM;
        else          w_estado_prox = CONV;
      end
      FIM: begin
        if (start) w_estado_prox = CONV;
        else       w_estado_prox = IDLE;
      end
      default: w_estado_prox = IDLE;
    endcase
  end

  // Flag values for the coming state; registered below so outputs are glitch-free
  always_comb begin
    w_busy_prox = 1'b0;
    w_done_prox = 1'b0;
    case (w_estado_prox)
      IDLE: begin
        w_busy_prox = 1'b0;
        w_done_prox = 1'b0;
      end
      CONV: begin
        w_busy_prox = 1'b1;
        w_done_prox = 1'b0;
      end
      FIM: begin
        w_busy_prox = 1'b0;
        w_done_prox = 1'b1;
      end
      default: begin
        w_busy_prox = 1'b0;
        w_done_prox = 1'b0;
      end
    endcase
  end

  // Registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_prox;
      r_done <= w_done_prox;
    end
  end

  // Shift register, iteration counter and published digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_desloc <= '0;
      r_cnt    <= 4'd0;
      r_cent   <= 4'd0;
      r_dez    <= 4'd0;
      r_uni    <= 4'd0;
    end else begin
      case (r_estado)
        IDLE, FIM: begin
          if (start) begin
            r_desloc <= {{BCD_TOTAL_W{1'b0}}, bin};
            r_cnt    <= 4'd0;
          end
        end
        CONV: begin
          r_desloc <= w_deslocado;
          r_cnt    <= r_cnt + 4'd1;
          // Last iteration: the shifted nibbles are the final result
          if (w_ultimo) begin
            r_cent <= w_deslocado[N_BITS + 2*BCD_W +: BCD_W];
            r_dez  <= w_deslocado[N_BITS + 1*BCD_W +: BCD_W];
            r_uni  <= w_deslocado[N_BITS +: BCD_W];
          end
        end
        default: begin
          r_desloc <= '0;
          r_cnt    <= 4'd0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign centenas = r_cent;
  assign dezenas  = r_dez;
  assign unidades = r_uni;

endmodule

// File: tb/tb_conversor_bcd_8bits.sv
// Scoreboard bench for conversor_bcd_8bits: stimulus pushes decimal expectations,
// a negedge monitor checks every done pulse, its timing, busy and digit hold.
module tb_conversor_bcd_8bits;

  localparam int N = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bin   = 8'd0;
  logic       busy;
  logic       done;
  logic [3:0] centenas;
  logic [3:0] dezenas;
  logic [3:0] unidades;

  conversor_bcd_8bits #(.N_BITS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done),
    .centenas(centenas), .dezenas(dezenas), .unidades(unidades)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int d;
    int u;
    int done_cyc;
    int val;
  } exp_t;

  exp_t q[$];
  int last_c = 0, last_d = 0, last_u = 0;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  // Reference: plain decimal digits of the value, done N edges after acceptance
  task automatic push(input int v, input int accept_cyc);
    exp_t e;
    e.c = v / 100;
    e.d = (v / 10) % 10;
    e.u = v % 10;
    e.done_cyc = accept_cyc + N;
    e.val = v;
    q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      int exp_busy;
      chk("busy_and_done", int'(busy && done), 0);
      if (done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done at cycle %0d: actual=1 required=0", cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("centenas", int'(centenas), e.c);
          chk("dezenas", int'(dezenas), e.d);
          chk("unidades", int'(unidades), e.u);
          last_c = e.c;
          last_d = e.d;
          last_u = e.u;
        end
      end else begin
        chk("hold_centenas", int'(centenas), last_c);
        chk("hold_dezenas", int'(dezenas), last_d);
        chk("hold_unidades", int'(unidades), last_u);
      end
      if (q.size() > 0 && cyc > q[0].done_cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_timeout for value %0d: actual=none required=cycle %0d",
                 q[0].val, q[0].done_cyc);
        void'(q.pop_front());
      end
      exp_busy = (q.size() > 0 && cyc >= q[0].done_cyc - N && cyc < q[0].done_cyc) ? 1 : 0;
      chk("busy", int'(busy), exp_busy);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge while the DUT is in IDLE or FIM; returns at the FIM negedge
  task automatic conv(input int v, input bit hold);
    bin   = 8'(v);
    start = 1'b1;
    push(v, cyc + 1);
    @(negedge clk);
    if (!hold) start = 1'b0;
    repeat (N) @(negedge clk);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge
  task automatic async_reset();
    #2;
    rst = 1'b1;
    q.delete();
    last_c = 0;
    last_d = 0;
    last_u = 0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_centenas", int'(centenas), 0);
    chk("rst_dezenas", int'(dezenas), 0);
    chk("rst_unidades", int'(unidades), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int v;
    bit h;
    rst = 1'b1;
    #3;
    chk("por_busy", int'(busy), 0);
    chk("por_done", int'(done), 0);
    chk("por_centenas", int'(centenas), 0);
    chk("por_dezenas", int'(dezenas), 0);
    chk("por_unidades", int'(unidades), 0);
    #17;
    rst = 1'b0;
    idle(2);

    conv(0, 1'b0);   idle(2);
    conv(255, 1'b0); idle(2);
    conv(99, 1'b0);  idle(1);
    conv(100, 1'b0); idle(3);
    conv(5, 1'b0);
    conv(10, 1'b0);  idle(2);

    // start held through CONV while bin changes; FIM then takes the new value
    bin   = 8'd200;
    start = 1'b1;
    push(200, cyc + 1);
    @(negedge clk);
    bin = 8'd37;
    repeat (N) @(negedge clk);
    push(37, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (N) @(negedge clk);
    idle(2);

    // Reset during the 4th CONV cycle aborts the conversion
    bin   = 8'd123;
    start = 1'b1;
    push(123, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    async_reset();
    idle(12);
    conv(123, 1'b0); idle(2);

    repeat (30) begin
      v = int'($urandom_range(0, 255));
      h = 1'($urandom_range(0, 1));
      conv(v, h);
      if (!h) idle(int'($urandom_range(0, 3)));
    end
    start = 1'b0;
    idle(2);

    for (int k = 0; k < 256; k++) begin
      conv(k, 1'b1);
    end
    start = 1'b0;
    idle(N + 3);
    chk("pending_after_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
